// File: rtl/div_nsu_seq.sv
// Sequential radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
// Divide-by-zero completes immediately with Q = all ones, R = X and in_error set.
module div_nsu_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         is_signed,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         busy,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         out_valid,
    output logic         in_error
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  ay_q, ay_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sq_q, sq_d;
    logic          sr_q, sr_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          ov_q, ov_d;
    logic          err_q, err_d;

    logic          accept;
    logic          neg_x, neg_y;
    logic [N-1:0]  abs_x, abs_y;
    logic [N:0]    trial;

    // Handshake: a request is taken on any rising edge where in_valid && in_ready;
    // in_ready is high outside CALC, and out_valid holds the result until the next accept.
    assign in_ready  = (state_q != S_CALC);
    assign busy      = (state_q == S_CALC);
    assign accept    = in_valid && in_ready;
    assign Q         = q_q;
    assign R         = r_q;
    assign out_valid = ov_q;
    assign in_error  = err_q;

    // Magnitudes stay N bits wide; the signed minimum maps to 2^(N-1) unsigned.
    assign neg_x = is_signed && X[N-1];
    assign neg_y = is_signed && Y[N-1];
    assign abs_x = neg_x ? (~X + 1'b1) : X;
    assign abs_y = neg_y ? (~Y + 1'b1) : Y;

    // Shifted partial remainder minus divisor over N+1 bits; the MSB is the borrow.
    assign trial = {rem_q, quo_q[N-1]} - {1'b0, ay_q};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        ay_d    = ay_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        q_d     = q_q;
        r_d     = r_q;
        ov_d    = ov_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (Y == '0) begin
                        q_d     = '1;
                        r_d     = X;
                        ov_d    = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = abs_x;
                        ay_d    = abs_y;
                        sq_d    = is_signed && (X[N-1] ^ Y[N-1]);
                        sr_d    = is_signed && X[N-1];
                        cnt_d   = CW'(N);
                        ov_d    = 1'b0;
                        err_d   = 1'b0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (cnt_q != '0) begin
                    if (!trial[N]) begin
                        rem_d = trial[N-1:0];
                        quo_d = {quo_q[N-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[N-2:0], quo_q[N-1]};
                        quo_d = {quo_q[N-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    q_d     = sq_q ? (~quo_q + 1'b1) : quo_q;
                    r_d     = sr_q ? (~rem_q + 1'b1) : rem_q;
                    ov_d    = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            ay_q    <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            ay_q    <= ay_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_div_nsu_seq.sv
// Bench for div_nsu_seq: directed N=32 cases and a random N=8 regression,
// both checked by queue scoreboards against an arithmetic reference.
module tb_div_nsu_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // N=32 instance
    logic        rst32 = 1'b1;
    logic [31:0] x32 = '0, y32 = '0;
    logic        s32 = 1'b0, iv32 = 1'b0;
    logic        ir32, busy32, ov32, err32;
    logic [31:0] q32, r32;

    // N=8 instance
    logic        rst8 = 1'b1;
    logic [7:0]  x8 = '0, y8 = '0;
    logic        s8 = 1'b0, iv8 = 1'b0;
    logic        ir8, busy8, ov8, err8;
    logic [7:0]  q8, r8;

    div_nsu_seq #(.N(32)) u_div32 (
        .clk(clk), .rst(rst32), .X(x32), .Y(y32), .is_signed(s32), .in_valid(iv32),
        .in_ready(ir32), .busy(busy32), .Q(q32), .R(r32), .out_valid(ov32), .in_error(err32)
    );

    div_nsu_seq #(.N(8)) u_div8 (
        .clk(clk), .rst(rst8), .X(x8), .Y(y8), .is_signed(s8), .in_valid(iv8),
        .in_ready(ir8), .busy(busy8), .Q(q8), .R(r8), .out_valid(ov8), .in_error(err8)
    );

    logic [64:0] exp32_q[$];
    logic [16:0] exp8_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: truncating division on plain integers, returns {err, Q[31:0], R[31:0]}.
    function automatic logic [64:0] ref_div(input int w, input longint xu, input longint yu, input bit s);
        longint p, h, xs, ys, q, r;
        p = longint'(1) << w;
        h = p >> 1;
        if (yu == 0) begin
            q = p - 1;
            return {1'b1, q[31:0], xu[31:0]};
        end
        if (s) begin
            xs = (xu >= h) ? xu - p : xu;
            ys = (yu >= h) ? yu - p : yu;
            q = xs / ys;
            r = xs % ys;
        end else begin
            q = xu / yu;
            r = xu % yu;
        end
        q = q & (p - 1);
        r = r & (p - 1);
        return {1'b0, q[31:0], r[31:0]};
    endfunction

    // Monitors: a new result is out_valid rising, or out_valid staying high across an accept.
    logic acc32 = 1'b0, prev32 = 1'b0, acc8 = 1'b0, prev8 = 1'b0;
    always @(posedge clk) acc32 <= iv32 && ir32 && !rst32;
    always @(posedge clk) acc8  <= iv8 && ir8 && !rst8;

    always @(negedge clk) begin : mon32
        logic [64:0] e;
        if (ov32 && (!prev32 || acc32)) begin
            if (exp32_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected32: got result q=%0h r=%0h, expected none", q32, r32);
            end else begin
                e = exp32_q.pop_front();
                check("q32", 64'(q32), 64'(e[63:32]));
                check("r32", 64'(r32), 64'(e[31:0]));
                check("err32", 64'(err32), 64'(e[64]));
            end
        end
        prev32 <= ov32;
    end

    always @(negedge clk) begin : mon8
        logic [16:0] e;
        if (ov8 && (!prev8 || acc8)) begin
            if (exp8_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected8: got result q=%0h r=%0h, expected none", q8, r8);
            end else begin
                e = exp8_q.pop_front();
                check("q8", 64'(q8), 64'(e[15:8]));
                check("r8", 64'(r8), 64'(e[7:0]));
                check("err8", 64'(err8), 64'(e[16]));
            end
        end
        prev8 <= ov8;
    end

    task automatic wait_ready32;
        int t = 0;
        while (!ir32 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("ready32_timeout", 64'(ir32), 64'(1));
    endtask

    task automatic wait_done32;
        int t = 0;
        while (exp32_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("done32_timeout", 64'(exp32_q.size()), 64'(0));
    endtask

    // Drive one request at a negedge where in_ready is high; it is taken at the next posedge.
    task automatic issue32(input logic [31:0] x, input logic [31:0] y, input bit s);
        wait_ready32();
        x32 = x;
        y32 = y;
        s32 = s;
        iv32 = 1'b1;
        exp32_q.push_back(ref_div(32, longint'(x), longint'(y), s));
        @(negedge clk);
        iv32 = 1'b0;
        x32 = $urandom;
        y32 = $urandom;
        s32 = ~s;
    endtask

    task automatic wait_ready8;
        int t = 0;
        while (!ir8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("ready8_timeout", 64'(ir8), 64'(1));
    endtask

    task automatic wait_done8;
        int t = 0;
        while (exp8_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("done8_timeout", 64'(exp8_q.size()), 64'(0));
    endtask

    task automatic run32;
        int cyc;
        logic [31:0] ry;
        // 100/7 with exact latency from accept edge to out_valid
        wait_ready32();
        x32 = 32'd100; y32 = 32'd7; s32 = 1'b0; iv32 = 1'b1;
        exp32_q.push_back(ref_div(32, 100, 7, 1'b0));
        @(negedge clk);
        iv32 = 1'b0;
        x32 = '1;
        y32 = 32'd1;
        cyc = 0;
        while (!ov32 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency32", 64'(cyc), 64'(33));
        wait_done32();

        // Requests while busy must be ignored
        issue32(32'hFFFFFFF9, 32'd2, 1'b1);
        check("busy32", 64'(busy32), 64'(1));
        check("in_ready_busy32", 64'(ir32), 64'(0));
        iv32 = 1'b1;
        x32 = 32'd55;
        y32 = 32'd5;
        repeat (5) @(negedge clk);
        iv32 = 1'b0;
        wait_done32();

        issue32(32'd7, 32'hFFFFFFFE, 1'b1);
        wait_done32();
        issue32(32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_done32();
        issue32(32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_done32();
        issue32(32'd1234, 32'd0, 1'b0);
        wait_done32();
        issue32(32'hFFFFFF00, 32'd0, 1'b1);
        issue32(32'd50, 32'd0, 1'b0);
        wait_done32();

        // Reset at cycle 10 of a CALC
        issue32(32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        rst32 = 1'b1;
        exp32_q.delete();
        @(negedge clk);
        rst32 = 1'b0;
        check("rst_mid_q32", 64'(q32), 64'(0));
        check("rst_mid_r32", 64'(r32), 64'(0));
        check("rst_mid_ov32", 64'(ov32), 64'(0));
        check("rst_mid_busy32", 64'(busy32), 64'(0));
        check("rst_mid_ready32", 64'(ir32), 64'(1));
        issue32(32'd9, 32'd4, 1'b0);
        wait_done32();

        for (int i = 0; i < 150; i++) begin
            ry = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 100)) : 32'($urandom);
            issue32($urandom, ry, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) wait_done32();
        end
        wait_done32();
    endtask

    task automatic run8;
        logic [7:0] rx, ry;
        bit rs;
        for (int i = 0; i < 3000; i++) begin
            wait_ready8();
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 15))
                0: begin rx = 8'($urandom); ry = 8'd0; end
                1: begin rx = 8'h80; ry = 8'hFF; end
                default: begin rx = 8'($urandom); ry = 8'($urandom); end
            endcase
            x8 = rx;
            y8 = ry;
            s8 = rs;
            iv8 = 1'b1;
            exp8_q.push_back({ref_div(8, longint'(rx), longint'(ry), rs)[64],
                              ref_div(8, longint'(rx), longint'(ry), rs)[39:32],
                              ref_div(8, longint'(rx), longint'(ry), rs)[7:0]});
            @(negedge clk);
            iv8 = 1'b0;
            x8 = 8'($urandom);
            y8 = 8'($urandom);
            if ($urandom_range(0, 2) == 0 && !ir8) begin
                iv8 = 1'b1;
                @(negedge clk);
                iv8 = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) wait_done8();
        end
        wait_done8();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of run, expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_q32", 64'(q32), 64'(0));
        check("rst_r32", 64'(r32), 64'(0));
        check("rst_ov32", 64'(ov32), 64'(0));
        check("rst_err32", 64'(err32), 64'(0));
        check("rst_busy32", 64'(busy32), 64'(0));
        check("rst_ready32", 64'(ir32), 64'(1));
        check("rst_ov8", 64'(ov8), 64'(0));
        check("rst_ready8", 64'(ir8), 64'(1));
        rst32 = 1'b0;
        rst8 = 1'b0;
        fork
            run32();
            run8();
        join
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
